// File: rtl/pipeline_hazard_ctrl.sv
// Stage-register control for the kanade32 5-stage pipeline: stalls, flushes,
// the dmem-wait watchdog and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int DMEM_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        fd_use_rs,
    input  logic        fd_use_rt,
    input  logic        de_mem_read,
    input  logic [4:0]  de_dst_reg,
    input  logic        em_redirect,
    input  logic        em_mem_access,
    input  logic        dmem_ready,
    input  logic        imem_ready,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        de_wren,
    output logic        em_wren,
    output logic        mw_wren,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_flush,
    output logic [1:0]  state,
    output logic        bus_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int WW = $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          bus_err_q, bus_err_d;
    logic          dfreeze, load_use, redirect_taken;

    assign dfreeze  = em_mem_access & ~dmem_ready;
    assign load_use = de_mem_read & (de_dst_reg != 5'd0) &
                      ((fd_use_rs & (fd_rs == de_dst_reg)) |
                       (fd_use_rt & (fd_rt == de_dst_reg)));
    assign redirect_taken = reset_n & (state_q != ERR) & ~dfreeze & em_redirect;

    assign state   = state_q;
    assign bus_err = bus_err_q;

    // Priority chain; a load-use hazard also masks imem wait so FD stays held.
    always_comb begin
        pc_wren  = 1'b1;
        fd_wren  = 1'b1;
        de_wren  = 1'b1;
        em_wren  = 1'b1;
        mw_wren  = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        if (!reset_n || state_q == ERR || dfreeze) begin
            pc_wren = 1'b0;
            fd_wren = 1'b0;
            de_wren = 1'b0;
            em_wren = 1'b0;
            mw_wren = 1'b0;
        end else if (em_redirect) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
        end else if (load_use) begin
            pc_wren  = 1'b0;
            fd_wren  = 1'b0;
            de_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_wren  = 1'b0;
            fd_flush = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bus_err_d = bus_err_q;
        case (state_q)
            RUN: begin
                if (dfreeze) begin
                    state_d = DWAIT;
                    wait_d  = WW'(1);
                end
            end
            DWAIT: begin
                // A dropped em_mem_access means the access was abandoned, not failed.
                if (!em_mem_access || dmem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WW'(DMEM_TIMEOUT - 1)) begin
                    state_d   = ERR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            if (state_q != ERR && !pc_wren && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect_taken && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected
// outputs into a queue, an independent monitor pops and compares each cycle.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  fd_rs, fd_rt, de_dst_reg;
    logic        fd_use_rs, fd_use_rt, de_mem_read;
    logic        em_redirect, em_mem_access, dmem_ready, imem_ready;
    logic        pc_wren, fd_wren, de_wren, em_wren, mw_wren;
    logic        fd_flush, de_flush, em_flush;
    logic [1:0]  state;
    logic        bus_err;
    logic [31:0] stall_cnt, flush_cnt;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        string       name;
        logic [4:0]  wren;
        logic [2:0]  flush;
        logic [1:0]  state;
        logic        berr;
        logic [31:0] stall;
        logic [31:0] fcnt;
    } exp_t;

    exp_t sb[$];

    pipeline_hazard_ctrl #(.DMEM_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_use_rs(fd_use_rs), .fd_use_rt(fd_use_rt),
        .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg),
        .em_redirect(em_redirect), .em_mem_access(em_mem_access),
        .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .pc_wren(pc_wren), .fd_wren(fd_wren), .de_wren(de_wren),
        .em_wren(em_wren), .mw_wren(mw_wren),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
        .state(state), .bus_err(bus_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic compareVal(input string nm, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%0h expected=%0h", nm, field, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareVal(e.name, "wren",  32'({pc_wren, fd_wren, de_wren, em_wren, mw_wren}), 32'(e.wren));
        compareVal(e.name, "flush", 32'({fd_flush, de_flush, em_flush}), 32'(e.flush));
        compareVal(e.name, "state", 32'(state), 32'(e.state));
        compareVal(e.name, "bus_err", 32'(bus_err), 32'(e.berr));
        compareVal(e.name, "stall_cnt", stall_cnt, e.stall);
        compareVal(e.name, "flush_cnt", flush_cnt, e.fcnt);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic applyStimulus(
        input string nm, input logic rst,
        input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
        input logic dmr, input logic [4:0] dst,
        input logic redir, input logic macc, input logic dready, input logic iready,
        input logic [4:0] ew, input logic [2:0] ef, input logic [1:0] es,
        input logic eb, input logic [31:0] esc, input logic [31:0] efc);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rst; fd_rs = rs; fd_rt = rt; fd_use_rs = urs; fd_use_rt = urt;
        de_mem_read = dmr; de_dst_reg = dst; em_redirect = redir;
        em_mem_access = macc; dmem_ready = dready; imem_ready = iready;
        e.name = nm; e.wren = ew; e.flush = ef; e.state = es;
        e.berr = eb; e.stall = esc; e.fcnt = efc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL drain actual=%0d expected=0 pending entries", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset_n = 1'b0; fd_rs = '0; fd_rt = '0; fd_use_rs = 1'b0; fd_use_rt = 1'b0;
        de_mem_read = 1'b0; de_dst_reg = '0; em_redirect = 1'b0;
        em_mem_access = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
        repeat (2) @(posedge clk);

        //             name            rst rs rt urs urt dmr dst red mac drd ird  wren      flush   st  be stall          fcnt
        applyStimulus("reset",         0,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b00000, 3'b000, 0, 0, 32'd0,         32'd0);
        applyStimulus("idle",          1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b11111, 3'b000, 0, 0, 32'd0,         32'd0);
        applyStimulus("lu_rs",         1,  5, 0, 1,  0,  1,  5,  0,  0,  1,  1,  5'b00111, 3'b010, 0, 0, 32'd0,         32'd0);
        applyStimulus("after_lu",      1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b11111, 3'b000, 0, 0, 32'd1,         32'd0);
        applyStimulus("lu_dst0",       1,  0, 0, 1,  0,  1,  0,  0,  0,  1,  1,  5'b11111, 3'b000, 0, 0, 32'd1,         32'd0);
        applyStimulus("lu_rt_unused",  1,  3, 7, 1,  0,  1,  7,  0,  0,  1,  1,  5'b11111, 3'b000, 0, 0, 32'd1,         32'd0);
        applyStimulus("lu_rt",         1,  3, 7, 1,  1,  1,  7,  0,  0,  1,  1,  5'b00111, 3'b010, 0, 0, 32'd1,         32'd0);
        applyStimulus("imem_wait",     1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  0,  5'b01111, 3'b100, 0, 0, 32'd2,         32'd0);
        applyStimulus("lu_imem",       1,  5, 0, 1,  0,  1,  5,  0,  0,  1,  0,  5'b00111, 3'b010, 0, 0, 32'd3,         32'd0);
        applyStimulus("redirect",      1,  5, 0, 1,  0,  1,  5,  1,  0,  1,  0,  5'b11111, 3'b111, 0, 0, 32'd4,         32'd0);
        applyStimulus("after_redir",   1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b11111, 3'b000, 0, 0, 32'd4,         32'd1);
        applyStimulus("dfrz1",         1,  0, 0, 0,  0,  0,  0,  0,  1,  0,  1,  5'b00000, 3'b000, 0, 0, 32'd4,         32'd1);
        applyStimulus("dfrz2",         1,  0, 0, 0,  0,  0,  0,  0,  1,  0,  1,  5'b00000, 3'b000, 1, 0, 32'd5,         32'd1);
        applyStimulus("dfrz3",         1,  0, 0, 0,  0,  0,  0,  0,  1,  0,  1,  5'b00000, 3'b000, 1, 0, 32'd6,         32'd1);
        applyStimulus("dready",        1,  0, 0, 0,  0,  0,  0,  0,  1,  1,  1,  5'b11111, 3'b000, 1, 0, 32'd7,         32'd1);
        applyStimulus("back_run",      1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b11111, 3'b000, 0, 0, 32'd7,         32'd1);
        applyStimulus("frz_vs_redir",  1,  0, 0, 0,  0,  0,  0,  1,  1,  0,  1,  5'b00000, 3'b000, 0, 0, 32'd7,         32'd1);
        applyStimulus("abandon",       1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b11111, 3'b000, 1, 0, 32'd8,         32'd1);
        applyStimulus("after_abandon", 1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b11111, 3'b000, 0, 0, 32'd8,         32'd1);
        applyStimulus("to1",           1,  0, 0, 0,  0,  0,  0,  0,  1,  0,  1,  5'b00000, 3'b000, 0, 0, 32'd8,         32'd1);
        applyStimulus("to2",           1,  0, 0, 0,  0,  0,  0,  0,  1,  0,  1,  5'b00000, 3'b000, 1, 0, 32'd9,         32'd1);
        applyStimulus("to3",           1,  0, 0, 0,  0,  0,  0,  0,  1,  0,  1,  5'b00000, 3'b000, 1, 0, 32'd10,        32'd1);
        applyStimulus("to4",           1,  0, 0, 0,  0,  0,  0,  0,  1,  0,  1,  5'b00000, 3'b000, 1, 0, 32'd11,        32'd1);
        applyStimulus("err",           1,  0, 0, 0,  0,  0,  0,  1,  0,  1,  1,  5'b00000, 3'b000, 2, 1, 32'd12,        32'd1);
        applyStimulus("err_hold",      1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b00000, 3'b000, 2, 1, 32'd12,        32'd1);
        applyStimulus("err_reset",     0,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b00000, 3'b000, 2, 1, 32'd12,        32'd1);
        applyStimulus("post_reset",    1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b11111, 3'b000, 0, 0, 32'd0,         32'd0);
        drain();

        // Preload the stall counter one below saturation instead of stalling 4G cycles.
        #1;
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;

        applyStimulus("sat_pre",       1,  5, 0, 1,  0,  1,  5,  0,  0,  1,  1,  5'b00111, 3'b010, 0, 0, 32'hFFFF_FFFE, 32'd0);
        applyStimulus("sat_hit",       1,  5, 0, 1,  0,  1,  5,  0,  0,  1,  1,  5'b00111, 3'b010, 0, 0, 32'hFFFF_FFFF, 32'd0);
        applyStimulus("sat_hold",      1,  0, 0, 0,  0,  0,  0,  0,  0,  1,  1,  5'b11111, 3'b000, 0, 0, 32'hFFFF_FFFF, 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
